hazard_stall_unit: RTL

//  Stall/flush controller that pairs with the forwarding unit.
//  - Forwarding resolves RAW hazards after the producer's result exists.
//  - This block handles the cases forwarding cannot cover:

---
 rtl/hazard_stall_unit_pkg.sv | 11 +
 rtl/hazard_stall_unit_sat_counter.sv | 31 +++
 rtl/hazard_stall_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the hazard stall/flush controller.
package hazard_stall_unit_pkg;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_MEM_WAIT = 1'b1
  } hz_state_e;

  localparam logic [4:0] NOP_RD = 5'd0;

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for load-use, data-memory wait and taken-branch redirect.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             me_mem_req,
  input  logic             me_mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_me_stall,
  output logic             id_ex_bubble,
  output logic             me_wb_bubble,
  output logic             if_id_flush,
  output logic             mem_wait,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WC_W = $clog2(WAIT_MAX + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(WAIT_MAX);

  hz_state_e       state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            lu_done_q, lu_done_d;
  logic            mem_timeout_q, mem_timeout_d;

  logic freeze;
  logic lu;
  logic lu_bubble;

  always_comb begin
    freeze = me_mem_req & ~me_mem_ready;
    lu = ex_mem_read & (ex_rd != NOP_RD) &
         ((id_use_rs1 & (ex_rd == id_rs1)) | (id_use_rs2 & (ex_rd == id_rs2)));

    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_me_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    me_wb_bubble = 1'b0;
    if_id_flush  = 1'b0;
    lu_bubble    = 1'b0;

    if (!rst) begin
      if (freeze) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_me_stall  = 1'b1;
        me_wb_bubble = 1'b1;
      end else if (ex_branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (lu && !lu_done_q) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_bubble = 1'b1;
        lu_bubble    = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HZ_RUN:      if (freeze)       state_d = HZ_MEM_WAIT;
      HZ_MEM_WAIT: if (me_mem_ready) state_d = HZ_RUN;
      default:                       state_d = HZ_RUN;
    endcase

    // wait_cnt counts frozen cycles; holding at WAIT_MAX keeps the compare stable
    wait_cnt_d = '0;
    if (freeze) begin
      wait_cnt_d = (wait_cnt_q == WC_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
    mem_timeout_d = mem_timeout_q | (freeze & (wait_cnt_d == WC_MAX));

    // A held EX (freeze) keeps the "already bubbled" memory for the same pair
    lu_done_d = lu_bubble | (freeze & lu_done_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HZ_RUN;
      wait_cnt_q    <= '0;
      lu_done_q     <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      lu_done_q     <= lu_done_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_wait    = (state_q == HZ_MEM_WAIT);
  assign mem_timeout = mem_timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_stall),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (if_id_flush),
    .count (flush_count)
  );

endmodule
